// File: rtl/jt12_sched_pkg.sv
// Shared definitions for the JT12 register-write scheduler: entry layout and FSM states.
package jt12_sched_pkg;

    localparam int unsigned ENTRY_W  = 17;
    localparam int unsigned BANK_BIT = 16;
    localparam int unsigned REG_MSB  = 15;
    localparam int unsigned VAL_MSB  = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POLL_A = 3'd1,
        S_STB_A  = 3'd2,
        S_GAP_A  = 3'd3,
        S_POLL_V = 3'd4,
        S_STB_V  = 3'd5,
        S_GAP_V  = 3'd6
    } state_t;

endpackage

// File: rtl/jt12_wr_fifo.sv
// Synchronous FIFO of {bank, reg, val} write entries with extra-bit pointers and occupancy.
module jt12_wr_fifo
    import jt12_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [ENTRY_W-1:0]       i_wdata,
    input  logic                     i_pop,
    output logic [ENTRY_W-1:0]       o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level   = r_wptr - r_rptr;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];
    // A simultaneous pop frees the slot, so a push into a full FIFO is still legal.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/jt12_wr_sched.sv
// JT12 register-write scheduler: round-robin arbiter, entry FIFO, and the
// address/data strobe sequencer that polls BUSY before each write.
module jt12_wr_sched
    import jt12_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 500,
    parameter int unsigned GAP          = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [16:0]            req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [16:0]            req1_data,
    output logic                   req1_ready,
    output logic                   cs_n,
    output logic                   wr_n,
    output logic [1:0]             addr,
    output logic [7:0]             dout,
    input  logic [7:0]             din,
    output logic                   idle,
    output logic                   timeout_err,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > GAP) ? BUSY_TIMEOUT : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    logic               r_last1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_push;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_err_set;
    logic               w_busy;
    logic               w_unused;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;

    logic               r_cs_n;
    logic               r_wr_n;
    logic [1:0]         r_addr;
    logic [7:0]         r_dout;
    logic               r_err;
    logic               w_strobe_nxt;
    logic [1:0]         w_addr_nxt;
    logic [7:0]         w_dout_nxt;

    assign w_busy   = din[7];
    assign w_unused = ^din[6:0];

    // Round-robin: on contention the requester not granted last wins.
    assign w_gnt1     = req1_valid && (!req0_valid || !r_last1);
    assign w_gnt0     = req0_valid && !w_gnt1;
    assign req0_ready = w_gnt0 && !w_full;
    assign req1_ready = w_gnt1 && !w_full;
    assign w_push     = req0_ready || req1_ready;
    assign w_wdata    = req1_ready ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_last1 <= 1'b1;
        else if (w_push) r_last1 <= req1_ready;
    end

    jt12_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // One counter serves both the BUSY timeout (POLL) and the idle gap (GAP).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_POLL_A;
                    w_cnt_nxt   = CW'(BUSY_TIMEOUT);
                end
            end
            S_POLL_A, S_POLL_V: begin
                if (!w_busy) begin
                    w_state_nxt = (r_state == S_POLL_A) ? S_STB_A : S_STB_V;
                end else if (r_cnt == '0) begin
                    w_err_set   = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_STB_A: begin
                w_state_nxt = S_GAP_A;
                w_cnt_nxt   = CW'(GAP - 1);
            end
            S_GAP_A: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_POLL_V;
                    w_cnt_nxt   = CW'(BUSY_TIMEOUT);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_STB_V: begin
                w_pop       = 1'b1;
                w_state_nxt = S_GAP_V;
                w_cnt_nxt   = CW'(GAP - 1);
            end
            S_GAP_V: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (!w_empty) begin
                    w_state_nxt = S_POLL_A;
                    w_cnt_nxt   = CW'(BUSY_TIMEOUT);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus values follow the next state so the strobe registers in the same edge as STB_*.
    always_comb begin
        w_strobe_nxt = 1'b0;
        w_addr_nxt   = r_addr;
        w_dout_nxt   = r_dout;
        if (w_state_nxt == S_STB_A) begin
            w_strobe_nxt = 1'b1;
            w_addr_nxt   = {w_head[BANK_BIT], 1'b0};
            w_dout_nxt   = w_head[REG_MSB -: 8];
        end else if (w_state_nxt == S_STB_V) begin
            w_strobe_nxt = 1'b1;
            w_addr_nxt   = {w_head[BANK_BIT], 1'b1};
            w_dout_nxt   = w_head[VAL_MSB -: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n <= 1'b1;
            r_wr_n <= 1'b1;
            r_addr <= '0;
            r_dout <= '0;
            r_err  <= 1'b0;
        end else begin
            r_cs_n <= !w_strobe_nxt;
            r_wr_n <= !w_strobe_nxt;
            r_addr <= w_addr_nxt;
            r_dout <= w_dout_nxt;
            r_err  <= r_err | w_err_set;
        end
    end

    assign cs_n        = r_cs_n;
    assign wr_n        = r_wr_n;
    assign addr        = r_addr;
    assign dout        = r_dout;
    assign timeout_err = r_err;
    assign idle        = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_jt12_wr_sched.sv
// Directed self-checking bench for jt12_wr_sched (main instance plus a short-timeout instance).
module tb_jt12_wr_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [16:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        cs_n, wr_n, idle, timeout_err;
    logic [1:0]  addr;
    logic [7:0]  dout, din;
    logic [3:0]  level;

    logic        b_req0_valid, b_req1_valid;
    logic [16:0] b_req0_data, b_req1_data;
    logic        b_req0_ready, b_req1_ready;
    logic        b_cs_n, b_wr_n, b_idle, b_timeout_err;
    logic [1:0]  b_addr;
    logic [7:0]  b_dout, b_din;
    logic [3:0]  b_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [1:0] addr;
        logic [7:0] dout;
        logic       csn;
    } stb_t;

    stb_t sq[$];
    stb_t sqb[$];

    jt12_wr_sched #(.DEPTH(8), .BUSY_TIMEOUT(500), .GAP(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .dout(dout), .din(din),
        .idle(idle), .timeout_err(timeout_err), .level(level)
    );

    jt12_wr_sched #(.DEPTH(8), .BUSY_TIMEOUT(10), .GAP(2)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .cs_n(b_cs_n), .wr_n(b_wr_n), .addr(b_addr), .dout(b_dout), .din(b_din),
        .idle(b_idle), .timeout_err(b_timeout_err), .level(b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorders, sampled 1ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (wr_n === 1'b0) sq.push_back('{cyc, addr, dout, cs_n});
        if (b_wr_n === 1'b0) sqb.push_back('{cyc, b_addr, b_dout, b_cs_n});
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = '0; b_req1_data = '0;
        din = 8'h00; b_din = 8'h00;
        repeat (3) tick();
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        checks++; if (wr_n !== 1'b1) begin failures++; $display("FAIL reset_wr_n got=%b exp=1", wr_n); end
        checks++; if (addr !== 2'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL reset_arb_favour got=%b exp=10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int k, n;
        sq.delete();
        req0_valid = 1'b1; req0_data = {1'b0, 8'h28, 8'hF0};
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
        tick();
        k = cyc;
        req0_valid = 1'b0;
        checks++; if (level !== 4'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
        n = 0;
        while (idle !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (idle !== 1'b1 || cyc != k + 9) begin
            failures++; $display("FAIL single_idle_cycle got=%0d exp=%0d idle=%b", cyc - k, 9, idle);
        end
        checks++; if (sq.size() != 2) begin failures++; $display("FAIL single_strobe_count got=%0d exp=2", sq.size()); end
        if (sq.size() == 2) begin
            checks++; if (sq[0].cyc != k + 2 || sq[0].addr !== 2'd0 || sq[0].dout !== 8'h28 || sq[0].csn !== 1'b0) begin
                failures++; $display("FAIL single_addr_strobe got=cyc+%0d a=%0d d=%h cs=%b exp=cyc+2 a=0 d=28 cs=0",
                                     sq[0].cyc - k, sq[0].addr, sq[0].dout, sq[0].csn);
            end
            checks++; if (sq[1].cyc != k + 6 || sq[1].addr !== 2'd1 || sq[1].dout !== 8'hF0 || sq[1].csn !== 1'b0) begin
                failures++; $display("FAIL single_data_strobe got=cyc+%0d a=%0d d=%h cs=%b exp=cyc+6 a=1 d=f0 cs=0",
                                     sq[1].cyc - k, sq[1].addr, sq[1].dout, sq[1].csn);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] d0 [4];
        logic [16:0] d1 [4];
        logic [16:0] ex [8];
        int i0, i1, k0, n;
        logic exp1, r0, r1;
        for (int j = 0; j < 4; j++) begin
            d0[j] = {1'b0, 8'(8'h30 + j), 8'(8'hA0 + j)};
            d1[j] = {1'b1, 8'(8'h40 + j), 8'(8'hB0 + j)};
            ex[2*j]   = d1[j];
            ex[2*j+1] = d0[j];
        end
        sq.delete();
        i0 = 0; i1 = 0; k0 = 0;
        exp1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req0_valid = (i0 < 4); req0_data = d0[i0 % 4];
            req1_valid = (i1 < 4); req1_data = d1[i1 % 4];
            #1;
            r0 = req0_ready; r1 = req1_ready;
            checks++; if ({r0, r1} !== {!exp1, exp1}) begin
                failures++; $display("FAIL b2b_ready_c%0d got=%b%b exp=%b%b", c, r0, r1, !exp1, exp1);
            end
            tick();
            if (c == 0) k0 = cyc;
            if (r0) i0++;
            if (r1) i1++;
            exp1 = !exp1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (idle !== 1'b1 && n < 120) begin tick(); n++; end
        checks++; if (idle !== 1'b1 || sq.size() != 16) begin
            failures++; $display("FAIL b2b_drain got=%0d strobes idle=%b exp=16 idle=1", sq.size(), idle);
        end
        if (sq.size() == 16) begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (sq[2*j].addr !== {ex[j][16], 1'b0} || sq[2*j].dout !== ex[j][15:8] || sq[2*j].cyc != k0 + 2 + 8*j) begin
                    failures++; $display("FAIL b2b_addr_e%0d got=a%0d d%h cyc+%0d exp=a%0d d%h cyc+%0d", j,
                                         sq[2*j].addr, sq[2*j].dout, sq[2*j].cyc - k0, {ex[j][16], 1'b0}, ex[j][15:8], 2 + 8*j);
                end
                checks++;
                if (sq[2*j+1].addr !== {ex[j][16], 1'b1} || sq[2*j+1].dout !== ex[j][7:0] || sq[2*j+1].cyc != k0 + 6 + 8*j) begin
                    failures++; $display("FAIL b2b_data_e%0d got=a%0d d%h cyc+%0d exp=a%0d d%h cyc+%0d", j,
                                         sq[2*j+1].addr, sq[2*j+1].dout, sq[2*j+1].cyc - k0, {ex[j][16], 1'b1}, ex[j][7:0], 6 + 8*j);
                end
            end
        end
    endtask

    task automatic test_busy_poll();
        int n, bad, rel;
        sq.delete();
        din = 8'h00;
        req0_valid = 1'b1; req0_data = {1'b0, 8'h55, 8'h66};
        tick();
        req0_valid = 1'b0;
        n = 0;
        while (sq.size() < 1 && n < 10) begin tick(); n++; end
        checks++; if (sq.size() != 1) begin failures++; $display("FAIL busy_addr_wait got=%0d exp=1", sq.size()); end
        din = 8'h80;
        bad = 0;
        for (int c = 0; c < 22; c++) begin
            tick();
            if (wr_n !== 1'b1 || addr !== 2'd0 || dout !== 8'h55) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL busy_hold got=%0d bad cycles exp=0", bad); end
        din = 8'h00;
        rel = cyc;
        n = 0;
        while (sq.size() < 2 && n < 10) begin tick(); n++; end
        checks++; if (sq.size() != 2) begin failures++; $display("FAIL busy_data_wait got=%0d exp=2", sq.size()); end
        if (sq.size() == 2) begin
            checks++; if (sq[1].cyc != rel + 1 || sq[1].addr !== 2'd1 || sq[1].dout !== 8'h66) begin
                failures++; $display("FAIL busy_data_strobe got=rel+%0d a=%0d d=%h exp=rel+1 a=1 d=66",
                                     sq[1].cyc - rel, sq[1].addr, sq[1].dout);
            end
        end
        n = 0;
        while (idle !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL busy_idle got=%b exp=1", idle); end
    endtask

    task automatic test_timeout();
        int k, n;
        sqb.delete();
        b_din = 8'h80;
        b_req0_valid = 1'b1; b_req0_data = {1'b0, 8'h11, 8'h22};
        tick();
        k = cyc;
        b_req0_data = {1'b0, 8'h33, 8'h44};
        tick();
        b_req0_valid = 1'b0;
        repeat (10) tick();
        checks++; if (b_timeout_err !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", b_timeout_err); end
        tick();
        checks++; if (b_timeout_err !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", b_timeout_err); end
        checks++; if (b_level !== 4'd1) begin failures++; $display("FAIL to_level got=%0d exp=1", b_level); end
        checks++; if (sqb.size() != 0) begin failures++; $display("FAIL to_no_strobe got=%0d exp=0", sqb.size()); end
        b_din = 8'h00;
        n = 0;
        while (b_idle !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (b_idle !== 1'b1 || sqb.size() != 2) begin
            failures++; $display("FAIL to_next_entry got=%0d strobes idle=%b exp=2 idle=1", sqb.size(), b_idle);
        end
        if (sqb.size() == 2) begin
            checks++; if (sqb[0].cyc != k + 14 || sqb[0].addr !== 2'd0 || sqb[0].dout !== 8'h33) begin
                failures++; $display("FAIL to_addr_strobe got=cyc+%0d a=%0d d=%h exp=cyc+14 a=0 d=33",
                                     sqb[0].cyc - k, sqb[0].addr, sqb[0].dout);
            end
            checks++; if (sqb[1].cyc != k + 18 || sqb[1].addr !== 2'd1 || sqb[1].dout !== 8'h44) begin
                failures++; $display("FAIL to_data_strobe got=cyc+%0d a=%0d d=%h exp=cyc+18 a=1 d=44",
                                     sqb[1].cyc - k, sqb[1].addr, sqb[1].dout);
            end
        end
        checks++; if (b_timeout_err !== 1'b1 || b_req1_ready !== 1'b0) begin
            failures++; $display("FAIL to_sticky got=err%b r1%b exp=err1 r10", b_timeout_err, b_req1_ready);
        end
    endtask

    task automatic test_fill();
        logic [16:0] fd [8];
        int n;
        sq.delete();
        din = 8'h80;
        for (int i = 0; i < 8; i++) begin
            fd[i] = {1'(i % 2), 8'(8'h60 + i), 8'(8'hC0 + i)};
            req0_valid = 1'b1; req0_data = fd[i];
            tick();
        end
        req0_valid = 1'b0;
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL fill_level got=%0d exp=8", level); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 17'h1_EEEE; req1_data = 17'h1_DDDD;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
            failures++; $display("FAIL fill_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL fill_level_hold got=%0d exp=8", level); end
        checks++; if (sq.size() != 0) begin failures++; $display("FAIL fill_no_strobe got=%0d exp=0", sq.size()); end
        din = 8'h00;
        n = 0;
        while (idle !== 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (idle !== 1'b1 || sq.size() != 16 || level !== 4'd0) begin
            failures++; $display("FAIL fill_drain got=%0d strobes level=%0d idle=%b exp=16 level=0 idle=1", sq.size(), level, idle);
        end
        if (sq.size() == 16) begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (sq[2*j].addr !== {fd[j][16], 1'b0} || sq[2*j].dout !== fd[j][15:8] ||
                    sq[2*j+1].addr !== {fd[j][16], 1'b1} || sq[2*j+1].dout !== fd[j][7:0]) begin
                    failures++; $display("FAIL fill_order_e%0d got=a%0d d%h/a%0d d%h exp entry=%h", j,
                                         sq[2*j].addr, sq[2*j].dout, sq[2*j+1].addr, sq[2*j+1].dout, fd[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        sq.delete();
        din = 8'h00;
        req0_valid = 1'b1; req0_data = {1'b0, 8'h71, 8'h72};
        tick();
        req0_data = {1'b1, 8'h73, 8'h74};
        tick();
        req0_valid = 1'b0;
        n = 0;
        while (sq.size() < 2 && n < 20) begin tick(); n++; end
        checks++; if (sq.size() != 2 || wr_n !== 1'b0) begin
            failures++; $display("FAIL rstmid_reach_stbv got=%0d strobes wr_n=%b exp=2 wr_n=0", sq.size(), wr_n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({cs_n, wr_n} !== 2'b11) begin failures++; $display("FAIL rstmid_strobe got=%b%b exp=11", cs_n, wr_n); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", level); end
        checks++; if (b_timeout_err !== 1'b0) begin failures++; $display("FAIL rstmid_err_clear got=%b exp=0", b_timeout_err); end
        sq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++; if (sq.size() != 0 || idle !== 1'b1) begin
            failures++; $display("FAIL rstmid_quiet got=%0d strobes idle=%b exp=0 idle=1", sq.size(), idle);
        end
        req0_valid = 1'b1; req0_data = {1'b1, 8'h77, 8'h88};
        tick();
        req0_valid = 1'b0;
        n = 0;
        while (idle !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (sq.size() != 2) begin failures++; $display("FAIL rstmid_new_count got=%0d exp=2", sq.size()); end
        if (sq.size() == 2) begin
            checks++; if (sq[0].addr !== 2'd2 || sq[0].dout !== 8'h77 || sq[1].addr !== 2'd3 || sq[1].dout !== 8'h88) begin
                failures++; $display("FAIL rstmid_new_write got=a%0d d%h/a%0d d%h exp=a2 d77/a3 d88",
                                     sq[0].addr, sq[0].dout, sq[1].addr, sq[1].dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_poll();
        test_timeout();
        test_fill();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
